// File: rtl/hls_mem_pkg.sv
// -----------------------------------------------------------------------------
// hls_mem_pkg
//
// Shared definitions for the HLS RAM responder blocks.
//   - Default address/data widths used by generated kernels.
//   - The clear-sequencer state type. CLEAR means the memory is being zeroed
//     and busy is raised. READY means normal kernel access.
// -----------------------------------------------------------------------------
package hls_mem_pkg;

  localparam int HLS_MEM_ADDR_WIDTH = 4;
  localparam int HLS_MEM_DATA_WIDTH = 32;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clear_state_e;

endpackage : hls_mem_pkg

// File: rtl/hls_ram_1r1w_if.sv
// -----------------------------------------------------------------------------
// hls_ram_1r1w_if
//
// Bundle of the kernel-facing RAM signals. The kernel (or a testbench standing
// in for it) uses the master modport, and the RAM responder uses the slave
// modport. clk and rst are not part of the bundle. They are plain ports on
// each block.
//
// Signals:
//   soft_rst          kernel clear request (kernel arg_N_rst)
//   raddr_0/rdata_0   functional combinational read port
//   waddr_0/wdata_0/  functional synchronous write port
//   wen_0
//   debug_addr/       debug combinational read port
//   debug_data
//   debug_write_*     debug synchronous write port
//   busy              clear sequence in progress
// -----------------------------------------------------------------------------
interface hls_ram_1r1w_if
  import hls_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = HLS_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = HLS_MEM_DATA_WIDTH
) ();

  logic                  soft_rst;

  logic [ADDR_WIDTH-1:0] raddr_0;
  logic [DATA_WIDTH-1:0] rdata_0;

  logic [ADDR_WIDTH-1:0] waddr_0;
  logic [DATA_WIDTH-1:0] wdata_0;
  logic                  wen_0;

  logic [ADDR_WIDTH-1:0] debug_addr;
  logic [DATA_WIDTH-1:0] debug_data;

  logic [ADDR_WIDTH-1:0] debug_write_addr;
  logic [DATA_WIDTH-1:0] debug_write_data;
  logic                  debug_write_en;

  logic                  busy;

  // Kernel side: issues addresses, write data and clear requests.
  modport master (
    output soft_rst,
    output raddr_0,
    input  rdata_0,
    output waddr_0,
    output wdata_0,
    output wen_0,
    output debug_addr,
    input  debug_data,
    output debug_write_addr,
    output debug_write_data,
    output debug_write_en,
    input  busy
  );

  // RAM side: answers reads, commits writes and reports clear progress.
  modport slave (
    input  soft_rst,
    input  raddr_0,
    output rdata_0,
    input  waddr_0,
    input  wdata_0,
    input  wen_0,
    input  debug_addr,
    output debug_data,
    input  debug_write_addr,
    input  debug_write_data,
    input  debug_write_en,
    output busy
  );

endinterface : hls_ram_1r1w_if

// File: rtl/hls_ram_clear_seq.sv
// -----------------------------------------------------------------------------
// hls_ram_clear_seq
//
// Zeroing sequencer for hls_ram_1r1w. After a hard reset (rst) or a
// kernel-issued soft reset (soft_rst), it walks clear_ptr from 0 to DEPTH-1.
// It requests one zero write per cycle. It then drops busy.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high hard reset (has priority over soft_rst)
//   soft_rst  synchronous, active-high restart of the clear sequence
//   clr_en    zero-write request for clr_addr on this edge
//   clr_addr  entry being cleared (current clear_ptr)
//   busy      high while in CLEAR. Registered, and its reset value is 1.
//
// busy is high for exactly DEPTH cycles after the last rst or soft_rst edge.
// The restarting edge itself performs no clear write. Entry 0 is cleared on
// the following edge.
// -----------------------------------------------------------------------------
module hls_ram_clear_seq
  import hls_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = HLS_MEM_ADDR_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_rst,
  output logic                  clr_en,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  busy
);

  // State codes are kept as plain vectors so the register stays a bare
  // logic vector. The values come from the shared enum.
  localparam logic [0:0] ST_CLEAR = CLEAR;
  localparam logic [0:0] ST_READY = READY;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [0:0]            state_q;
  logic [ADDR_WIDTH-1:0] clear_ptr_q;
  logic                  busy_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk) begin
    if (rst || soft_rst) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clear_ptr_q == LAST_ADDR) begin
            state_q     <= ST_READY;
            clear_ptr_q <= '0;
            busy_q      <= 1'b0;
          end else begin
            clear_ptr_q <= clear_ptr_q + 1'b1;
          end
        end
        default: begin
          state_q     <= ST_READY;
          clear_ptr_q <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Neither a hard-reset cycle nor a restarting cycle writes memory.
  assign clr_en   = busy_q && !rst && !soft_rst;
  assign clr_addr = clear_ptr_q;
  assign busy     = busy_q;

endmodule : hls_ram_clear_seq

// File: rtl/hls_ram_1r1w.sv
// -----------------------------------------------------------------------------
// hls_ram_1r1w
//
// Responder side of the HLS RAM interface. The memory has DEPTH words of
// DATA_WIDTH bits. It provides the following ports:
//   - one combinational functional read port (raddr_0 -> rdata_0),
//   - one synchronous functional write port (waddr_0/wdata_0/wen_0),
//   - one combinational debug read port (debug_addr -> debug_data),
//   - one synchronous debug write port (debug_write_*).
//
// While the clear sequencer is busy, both reads return 0 and all writes are
// dropped. Writes are also dropped in any cycle where rst or soft_rst is high.
// If both write ports target the same address, the debug write wins.
// Addresses at or above DEPTH are ignored on write and read as 0.
// A read during a write to the same address returns the old word.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (starts the clear sequence)
//   bus   hls_ram_1r1w_if slave modport (all kernel arg_N_* signals)
//
// Parameters:
//   ADDR_WIDTH  address width of every address port
//   DATA_WIDTH  data width of every data port
//   DEPTH       number of words, 1 <= DEPTH <= 2**ADDR_WIDTH
// -----------------------------------------------------------------------------
module hls_ram_1r1w
  import hls_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = HLS_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = HLS_MEM_DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic          clk,
  input  logic          rst,
  hls_ram_1r1w_if.slave bus
);

  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  busy;

  logic                  write_ok;
  logic                  func_we;
  logic                  dbg_we;
  logic                  func_commit;
  logic [DATA_WIDTH-1:0] rdata_mux;
  logic [DATA_WIDTH-1:0] debug_mux;

  // NOTE: storage has no reset. Clearing is done by the sequencer one word
  // per cycle, which keeps the array mappable to plain RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // The extra top bit lets DEPTH == 2**ADDR_WIDTH compare without overflow.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < (ADDR_WIDTH + 1)'(DEPTH);
  endfunction

  hls_ram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .soft_rst (bus.soft_rst),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  // ---------------------------------------------------------------------------
  // Write qualification and priority
  // ---------------------------------------------------------------------------
  assign write_ok = !busy && !rst && !bus.soft_rst;
  assign func_we  = write_ok && bus.wen_0 && in_range(bus.waddr_0);
  assign dbg_we   = write_ok && bus.debug_write_en && in_range(bus.debug_write_addr);

  // Suppress the functional write on a same-address collision. Then only one
  // port updates a given word on any edge.
  assign func_commit = func_we && !(dbg_we && (bus.debug_write_addr == bus.waddr_0));

  // clr_en and the functional/debug writes are mutually exclusive because
  // write_ok requires !busy.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end
    if (func_commit) begin
      mem[bus.waddr_0] <= bus.wdata_0;
    end
    if (dbg_we) begin
      mem[bus.debug_write_addr] <= bus.debug_write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational reads: these return the pre-edge word on read-during-write.
  // ---------------------------------------------------------------------------
  // NOTE: each output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    rdata_mux = '0;
    debug_mux = '0;
    if (!busy && in_range(bus.raddr_0)) begin
      rdata_mux = mem[bus.raddr_0];
    end
    if (!busy && in_range(bus.debug_addr)) begin
      debug_mux = mem[bus.debug_addr];
    end
  end

  assign bus.rdata_0    = rdata_mux;
  assign bus.debug_data = debug_mux;
  assign bus.busy       = busy;

endmodule : hls_ram_1r1w

// File: tb/tb_hls_ram_1r1w.sv
// -----------------------------------------------------------------------------
// tb_hls_ram_1r1w
//
// Drives identical stimulus into two RAM instances: DEPTH=16, which uses the
// full address space, and DEPTH=12, which has out-of-range addresses.
// Outputs are compared against a word-array reference model. The model treats
// a clear as "busy for DEPTH edges, then every word is zero", and it applies
// READY writes in port order with the debug port last.
// -----------------------------------------------------------------------------
module tb_hls_ram_1r1w;

  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          soft_rst;
  logic [AW-1:0] raddr_0;
  logic [AW-1:0] waddr_0;
  logic [DW-1:0] wdata_0;
  logic          wen_0;
  logic [AW-1:0] debug_addr;
  logic [AW-1:0] debug_write_addr;
  logic [DW-1:0] debug_write_data;
  logic          debug_write_en;

  hls_ram_1r1w_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_a ();
  hls_ram_1r1w_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b ();

  assign if_a.soft_rst         = soft_rst;
  assign if_a.raddr_0          = raddr_0;
  assign if_a.waddr_0          = waddr_0;
  assign if_a.wdata_0          = wdata_0;
  assign if_a.wen_0            = wen_0;
  assign if_a.debug_addr       = debug_addr;
  assign if_a.debug_write_addr = debug_write_addr;
  assign if_a.debug_write_data = debug_write_data;
  assign if_a.debug_write_en   = debug_write_en;

  assign if_b.soft_rst         = soft_rst;
  assign if_b.raddr_0          = raddr_0;
  assign if_b.waddr_0          = waddr_0;
  assign if_b.wdata_0          = wdata_0;
  assign if_b.wen_0            = wen_0;
  assign if_b.debug_addr       = debug_addr;
  assign if_b.debug_write_addr = debug_write_addr;
  assign if_b.debug_write_data = debug_write_data;
  assign if_b.debug_write_en   = debug_write_en;

  hls_ram_1r1w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  hls_ram_1r1w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(12)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  // ---------------------------------------------------------------------------
  // Reference model: index 0 -> dut_a, index 1 -> dut_b
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mdl [2][16];
  int            busy_left [2];
  int            tests_run    = 0;
  int            tests_failed = 0;

  function automatic int depth_of(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic logic [DW-1:0] exp_read(input int k, input logic [AW-1:0] a);
    if (busy_left[k] > 0 || int'(a) >= depth_of(k)) return '0;
    return mdl[k][a];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst || soft_rst) begin
        busy_left[k] = depth_of(k);
      end else if (busy_left[k] > 0) begin
        busy_left[k] = busy_left[k] - 1;
        if (busy_left[k] == 0) begin
          for (int i = 0; i < 16; i++) mdl[k][i] = '0;
        end
      end else begin
        if (wen_0 && int'(waddr_0) < depth_of(k)) mdl[k][waddr_0] = wdata_0;
        if (debug_write_en && int'(debug_write_addr) < depth_of(k))
          mdl[k][debug_write_addr] = debug_write_data;
      end
    end
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances against the model, mid-cycle.
  task automatic settle();
    @(negedge clk);
    check("a.busy",  {31'b0, if_a.busy},  {31'b0, busy_left[0] > 0});
    check("a.rdata", if_a.rdata_0,        exp_read(0, raddr_0));
    check("a.debug", if_a.debug_data,     exp_read(0, debug_addr));
    check("b.busy",  {31'b0, if_b.busy},  {31'b0, busy_left[1] > 0});
    check("b.rdata", if_b.rdata_0,        exp_read(1, raddr_0));
    check("b.debug", if_b.debug_data,     exp_read(1, debug_addr));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    settle();
    step();
  endtask

  task automatic idle_inputs();
    soft_rst         = 1'b0;
    raddr_0          = '0;
    waddr_0          = '0;
    wdata_0          = '0;
    wen_0            = 1'b0;
    debug_addr       = '0;
    debug_write_addr = '0;
    debug_write_data = '0;
    debug_write_en   = 1'b0;
  endtask

  // Runs until dut_a leaves CLEAR, bounded by 40 cycles. It leaves the bench
  // settled mid-cycle. na counts busy cycles of dut_a, and nb those of dut_b.
  task automatic wait_ready(output int na, output int nb);
    na = 0;
    nb = 0;
    settle();
    while (if_a.busy === 1'b1 && na < 40) begin
      if (if_b.busy === 1'b1) nb++;
      step();
      na++;
      settle();
    end
  endtask

  int na;
  int nb;

  initial begin
    for (int k = 0; k < 2; k++) begin
      busy_left[k] = depth_of(k);
      for (int i = 0; i < 16; i++) mdl[k][i] = '0;
    end
    idle_inputs();

    // Reset held for two edges, then a clear of DEPTH cycles.
    rst = 1'b1;
    step();
    settle();
    check("rst_busy", {31'b0, if_a.busy}, 32'd1);
    check("rst_rdata_zero", if_a.rdata_0, 32'd0);
    step();
    rst = 1'b0;
    wait_ready(na, nb);
    check("rst_busy_len_a", 32'(na), 32'd16);
    check("rst_busy_len_b", 32'(nb), 32'd12);
    step();

    for (int i = 0; i < 16; i++) begin
      debug_addr = 4'(i);
      settle();
      check("clr_dbg_zero", if_a.debug_data, 32'h0000_0000);
      step();
    end

    // Read during write returns the old word. The new word appears next cycle.
    waddr_0 = 4'd5; wdata_0 = 32'hDEAD_BEEF; wen_0 = 1'b1; raddr_0 = 4'd5;
    settle();
    check("rdw_old", if_a.rdata_0, 32'h0);
    step();
    wen_0 = 1'b0;
    settle();
    check("rdw_new", if_a.rdata_0, 32'hDEAD_BEEF);
    step();

    // Same-address collision: the debug port wins.
    waddr_0 = 4'd3; wdata_0 = 32'h1111_1111; wen_0 = 1'b1;
    debug_write_addr = 4'd3; debug_write_data = 32'h2222_2222; debug_write_en = 1'b1;
    raddr_0 = 4'd3;
    cycle();
    wen_0 = 1'b0; debug_write_en = 1'b0;
    settle();
    check("collide_same", if_a.rdata_0, 32'h2222_2222);
    step();

    // Different addresses: both writes commit.
    wen_0 = 1'b1; debug_write_addr = 4'd4; debug_write_en = 1'b1;
    cycle();
    wen_0 = 1'b0; debug_write_en = 1'b0;
    debug_addr = 4'd4;
    settle();
    check("collide_diff_func", if_a.rdata_0,    32'h1111_1111);
    check("collide_diff_dbg",  if_a.debug_data, 32'h2222_2222);
    step();

    // Soft reset, then a restart on the 5th CLEAR cycle.
    debug_write_addr = 4'd7; debug_write_data = 32'hA5A5_A5A5; debug_write_en = 1'b1;
    cycle();
    debug_write_en = 1'b0; raddr_0 = 4'd7;
    settle();
    check("preload7", if_a.rdata_0, 32'hA5A5_A5A5);
    step();
    soft_rst = 1'b1;
    cycle();
    soft_rst = 1'b0;
    repeat (4) cycle();
    soft_rst = 1'b1;
    cycle();
    soft_rst = 1'b0;
    wait_ready(na, nb);
    check("soft_busy_len", 32'(na), 32'd16);
    step();
    debug_addr = 4'd7;
    settle();
    check("soft_clr7_rd",  if_a.rdata_0,    32'h0);
    check("soft_clr7_dbg", if_a.debug_data, 32'h0);
    step();

    // Writes during CLEAR are dropped, and reads stay at 0 throughout.
    debug_write_addr = 4'd2; debug_write_data = 32'h0BAD_0002; debug_write_en = 1'b1;
    cycle();
    debug_write_en = 1'b0;
    soft_rst = 1'b1;
    cycle();
    soft_rst = 1'b0;
    waddr_0 = 4'd2; wdata_0 = 32'h1234_5678; wen_0 = 1'b1; raddr_0 = 4'd2;
    for (int i = 0; i < 16; i++) begin
      settle();
      check("busy_rd_zero", if_a.rdata_0, 32'h0);
      step();
    end
    settle();
    check("busy_done", {31'b0, if_a.busy}, 32'd0);
    wen_0 = 1'b0;
    step();
    settle();
    check("busy_wr_dropped", if_a.rdata_0, 32'h0);
    step();

    // Out of range on the DEPTH=12 instance.
    debug_write_addr = 4'd11; debug_write_data = 32'hCAFE_F00D; debug_write_en = 1'b1;
    cycle();
    debug_write_addr = 4'd0; debug_write_data = 32'h0BAD_C0DE;
    cycle();
    debug_write_en = 1'b0;
    waddr_0 = 4'd13; wdata_0 = 32'hFFFF_FFFF; wen_0 = 1'b1;
    cycle();
    wen_0 = 1'b0; raddr_0 = 4'd13;
    settle();
    check("oor_read_b", if_b.rdata_0, 32'h0);
    check("inrange_13_a", if_a.rdata_0, 32'hFFFF_FFFF);
    step();
    for (int i = 0; i < 12; i++) begin
      debug_addr = 4'(i);
      settle();
      check("oor_unchanged", if_b.debug_data, exp_read(1, debug_addr));
      step();
    end
    raddr_0 = 4'd11; debug_addr = 4'd0;
    settle();
    check("oor_keep11", if_b.rdata_0,    32'hCAFE_F00D);
    check("oor_keep0",  if_b.debug_data, 32'h0BAD_C0DE);
    step();

    // Randomized traffic, with occasional soft and hard resets.
    for (int n = 0; n < 600; n++) begin
      rst              = ($urandom_range(0, 249) == 0);
      soft_rst         = ($urandom_range(0, 59) == 0);
      wen_0            = 1'($urandom_range(0, 1));
      waddr_0          = 4'($urandom_range(0, 15));
      wdata_0          = $urandom;
      debug_write_en   = ($urandom_range(0, 2) == 0);
      debug_write_addr = ($urandom_range(0, 3) == 0) ? waddr_0 : 4'($urandom_range(0, 15));
      debug_write_data = $urandom;
      raddr_0          = ($urandom_range(0, 2) == 0) ? waddr_0 : 4'($urandom_range(0, 15));
      debug_addr       = 4'($urandom_range(0, 15));
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (20) cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_hls_ram_1r1w
